// File: rtl/stream_fifo_flex.sv
// stream_fifo_flex: valid/ready stream FIFO with any depth >= 2, a push into
// a full FIFO when a pop happens in the same cycle, a synchronous flush, and
// level / almost-full / almost-empty status taken from the registered count.
module stream_fifo_flex #(
    parameter  int unsigned WIDTH      = 8,
    parameter  int unsigned DEPTH      = 8,
    parameter  int unsigned AFULL_THR  = DEPTH - 1,
    parameter  int unsigned AEMPTY_THR = 1,
    localparam int unsigned LW         = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             down_valid,
    output logic [WIDTH-1:0] down_data,
    input  logic             down_ready,
    output logic [LW-1:0]    level_o,
    output logic             almost_full_o,
    output logic             almost_empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    // The last entry wraps to 0 by an explicit compare, so any DEPTH works.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // Handshake gating; a full FIFO still accepts when the head leaves this cycle.
    always_comb begin
        w_full     = (r_count == LW'(DEPTH));
        w_empty    = (r_count == '0);
        down_valid = !w_empty && !flush_i;
        up_ready   = !flush_i && (!w_full || down_ready);
        w_pop      = down_valid && down_ready;
        w_push     = up_valid && up_ready;
    end

    // Pointer and count state; flush wins over any handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + LW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - LW'(1);
            end
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= up_data;
        end
    end

    // First-word-fall-through head and status compares on the registered count.
    always_comb begin
        down_data      = r_mem[r_rd_ptr];
        level_o        = r_count;
        almost_full_o  = (r_count >= LW'(AFULL_THR));
        almost_empty_o = (r_count <= LW'(AEMPTY_THR));
    end

endmodule

// File: doc/stream_fifo_flex.md
# stream_fifo_flex

Parametrised valid/ready stream FIFO for the streaming datapath. Buffers DEPTH words of WIDTH bits between an upstream producer and a downstream consumer, and exposes a fill level and programmable almost-full/almost-empty flags. Differs from the plain wrapper FIFO in four ways: it supports arbitrary (non-power-of-two) depth, it accepts a push into a full FIFO when a pop happens in the same cycle, it has a synchronous flush, and it reports level and threshold status.

## Interface
- WIDTH, 8, data word width in bits (>= 1).
- DEPTH, 8, number of storage entries (>= 2, any integer).
- AFULL_THR, DEPTH-1, almost_full_o asserts when level >= AFULL_THR (1..DEPTH).
- AEMPTY_THR, 1, almost_empty_o asserts when level <= AEMPTY_THR (0..DEPTH-1).
- LW, $clog2(DEPTH+1), derived local width of the level counter; not overridable.

Ports:
- clk_i  in  1  the single clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; empties the FIFO.
- up_valid  in  1  upstream word valid.
- up_data  in  WIDTH  upstream word.
- up_ready  out  1  the FIFO accepts a word this cycle.
- down_valid  out  1  down_data holds the head word.
- down_data  out  WIDTH  head word (FWFT).
- down_ready  in  1  downstream consumes the head.
- level_o  out  LW  current number of stored words, 0..DEPTH.
- almost_full_o  out  1  level_o >= AFULL_THR.
- almost_empty_o  out  1  level_o <= AEMPTY_THR.

## Operation
- Storage: DEPTH x WIDTH register array, write pointer wr_ptr, read pointer rd_ptr, and count (LW bits). The array is not reset.
- Pointer wrap: a pointer at DEPTH-1 advances to 0, compared explicitly. Modulo-2^n wrap is prohibited, because DEPTH can be a non-power of two.
- pop = down_valid && down_ready.
- push = up_valid && up_ready.
- down_valid = (count != 0) && !flush_i.
- up_ready = !flush_i && ((count != DEPTH) || down_ready).
  - When full, a push is accepted only together with a pop in the same cycle.
  - This creates a combinational path from down_ready to up_ready. Upstream must not make up_valid depend on up_ready.
- down_data = mem[rd_ptr]. It is undefined whenever down_valid = 0.
- Update per edge:
  - Push only: write mem[wr_ptr]; wr_ptr++; count++.
  - Pop only: rd_ptr++; count--.
  - Push and pop: write, both pointers advance; count unchanged. This applies at full and at any partial level.
  - Push and pop when empty: impossible, since down_valid = 0 when empty.
- Flush has priority over everything. Pointers and count go to 0 on the next edge. Because up_ready and down_valid are forced low while flush_i = 1, no handshake completes during a flush cycle.
- level_o = count. almost_full_o and almost_empty_o are compares on the registered count (no lookahead).
- count never exceeds DEPTH and never underflows. Both are guaranteed by the ready/valid gating, not by saturation logic.

## Timing
- Reset (rst_ni low, asynchronous) values:
  - wr_ptr = rd_ptr = count = 0.
  - level_o = 0, down_valid = 0, up_ready = 1 (if flush_i = 0), almost_empty_o = 1, almost_full_o = 0.
  - Reset release is sampled on the clock edge. The first push is possible on the first edge after deassertion.
- Reset mid-operation: all contents are discarded immediately. Outputs take their reset values asynchronously.
- Latency: a word pushed at edge N is visible on down_data with down_valid = 1 after edge N. Minimum pass-through is 1 cycle; there is no same-cycle bypass when empty.
- Throughput: 1 word/cycle sustained, including at level = DEPTH with down_ready held high.
- level_o and both flags change on the edge following the handshake that caused the change.
- flush_i asserted in cycle N: outputs are gated in cycle N; level_o = 0 after edge N.

## Test plan
- Reset, then idle → level_o=0, down_valid=0, up_ready=1, almost_empty_o=1, almost_full_o=0.
- DEPTH=5, push 0x01..0x05 with down_ready=0 → level_o=5, up_ready=0, almost_full_o=1. Then pop all → data 0x01..0x05 in order, level_o returns to 0.
- DEPTH=5, full, up_valid=1 and down_ready=1 for 12 cycles with incrementing data → 12 words transferred, level_o stays 5, output order intact across pointer wrap at 4→0.
- Fill to 3, assert flush_i with up_valid=1 and down_ready=1 → no handshake that cycle, level_o=0 next cycle, down_valid=0. The next push of 0xAA appears as head one cycle later.
- Random valid/ready (50% each), 2000 words, DEPTH=7, AFULL_THR=6, AEMPTY_THR=2 → scoreboard matches, flags always consistent with level_o, level_o never exceeds 7.
- Assert rst_ni low mid-stream at level 4 → outputs at reset values before the next edge, and no stale word appears after release.
